unstall_sequencer: RTL

Parametrised successor to the pipeline unstalling logic. It takes the PC-enable/stall indication and drives a per-stage enable vector for NSTAGES pipeline stages. All stages are frozen on a stall. On release, stages are re-enabled one at a time, every STEP cycles, from front to back. It also reports stall length and release-in-progress status to the hazard/debug logic.

---
 rtl/unstall_sequencer_if.sv | 28 ++
 rtl/unstall_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/unstall_sequencer_if.sv
// Handshake bundle between the hazard logic and the unstall sequencer:
// stall request / flush in, per-stage enables and status out.
interface unstall_sequencer_if #(
   parameter int NSTAGES = 4,
   parameter int CNT_W   = 8
);
   logic               pc_en;
   logic               flush;
   logic [NSTAGES-1:0] stage_en;
   logic               unstalling;
   logic [CNT_W-1:0]   stall_cycles;

   modport master (
      output pc_en,
      output flush,
      input  stage_en,
      input  unstalling,
      input  stall_cycles
   );

   modport slave (
      input  pc_en,
      input  flush,
      output stage_en,
      output unstalling,
      output stall_cycles
   );
endinterface

// File: rtl/unstall_sequencer.sv
// Freezes all pipeline stages on a stall and re-enables them front to back,
// one stage every STEP cycles, while tracking the length of each stall episode.
module unstall_sequencer #(
   parameter int NSTAGES = 4,
   parameter int STEP    = 1,
   parameter int CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   unstall_sequencer_if.slave    bus
);

   localparam int SCNT_W = (STEP > 1) ? $clog2(STEP) : 1;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      STALL   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [NSTAGES-1:0]  stage_en_q, stage_en_d;
   logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
   logic [SCNT_W-1:0]   step_q, step_d;
   logic                run_req;
   logic [NSTAGES-1:0]  grow;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Only a clean 1 advances the PC; X/Z fall into the stall branch below.
   assign run_req = (bus.pc_en == 1'b1);
   assign grow    = (stage_en_q << 1) | NSTAGES'(1);

   always_comb begin
      state_d        = state_q;
      stage_en_d     = stage_en_q;
      stall_cycles_d = stall_cycles_q;
      step_d         = step_q;

      if (bus.flush == 1'b1) begin
         state_d    = RUN;
         stage_en_d = '1;
         step_d     = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (run_req) begin
                  stage_en_d = '1;
               end else begin
                  state_d        = STALL;
                  stage_en_d     = '0;
                  stall_cycles_d = CNT_W'(1);
               end
            end
            STALL: begin
               if (run_req) begin
                  step_d = '0;
                  if (NSTAGES == 1) begin
                     state_d    = RUN;
                     stage_en_d = '1;
                  end else begin
                     state_d    = RELEASE;
                     stage_en_d = NSTAGES'(1);
                  end
               end else begin
                  stage_en_d     = '0;
                  stall_cycles_d = sat_inc(stall_cycles_q);
               end
            end
            RELEASE: begin
               if (run_req) begin
                  if (step_q == SCNT_W'(STEP - 1)) begin
                     step_d     = '0;
                     stage_en_d = grow;
                     // Setting the last stage completes the release.
                     if (grow[NSTAGES-1]) begin
                        state_d = RUN;
                     end
                  end else begin
                     step_d = step_q + SCNT_W'(1);
                  end
               end else begin
                  state_d        = STALL;
                  stage_en_d     = '0;
                  stall_cycles_d = CNT_W'(1);
                  step_d         = '0;
               end
            end
            default: begin
               state_d    = RUN;
               stage_en_d = '1;
               step_d     = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RUN;
         stage_en_q     <= '1;
         stall_cycles_q <= '0;
         step_q         <= '0;
      end else begin
         state_q        <= state_d;
         stage_en_q     <= stage_en_d;
         stall_cycles_q <= stall_cycles_d;
         step_q         <= step_d;
      end
   end

   assign bus.stage_en     = stage_en_q;
   assign bus.unstalling   = (state_q == RELEASE);
   assign bus.stall_cycles = stall_cycles_q;

endmodule
